sdcard_sector_buffer: RTL and testbench
=======================================

SDCARD_SECTOR_BUFFER -- requirements
Module: sdcard_sector_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, as follows: clk  input  1  single clock; rst  input  1  synchronous active-high reset.
REQ-002 SHALL have dma_data  input  8  byte from the SD DMA stream.
REQ-003 SHALL have dma_addr  input  9  byte index within the sector, 0..511.
REQ-004 SHALL have dma_strobe  input  1  one-cycle byte-valid pulse.
REQ-005 SHALL have the host bus ports: sram_a input 10 host address; sram_d_in input 8 host write data; sram_d_out output 8 host read data; sram_cs, sram_oe, sram_we inputs 1 each; sram_wait output 1 read stall.
REQ-006 SHALL have sector_ready  output  1  high while at least one bank is FULL.

Function
REQ-007 SHALL contain NB banks of 512x8 storage, with NB=2 or NB=1 per REQ-025.
REQ-008 SHALL give each bank a state: EMPTY, FILLING or FULL.
REQ-009 SHALL keep pointers fill_bank (next/current fill) and rd_bank (oldest FULL); banks fill and drain in strict alternating FIFO order.
REQ-010 On strobe with addr=0 and bank[fill_bank] EMPTY or FILLING: SHALL write the byte at 0, set FILLING, and set expected count=1; addr=0 during FILLING restarts the same bank.
REQ-011 On strobe with addr=expected during FILLING: SHALL write the byte and increment expected.
REQ-012 On strobe with addr=0x1FF accepted: SHALL set the bank FULL next cycle and advance fill_bank modulo NB.
REQ-013 On strobe with addr≠expected (nonzero) during FILLING: SHALL set seq_err, return the bank to EMPTY, and drop the byte.
REQ-014 On strobe with addr≠0 while bank[fill_bank] is EMPTY: SHALL set seq_err and drop the byte.
REQ-015 On strobe while bank[fill_bank] is FULL: SHALL set overrun and drop the byte; subsequent bytes of that sector SHALL also be dropped until an addr=0 strobe finds a non-FULL bank.
REQ-016 Host read with sram_a[9]=1: SHALL return bank[rd_bank][sram_a[8:0]].
REQ-017 Host reads SHALL have one wait cycle: sram_wait=1 in the first cycle of cs&oe with a[9]=1, sram_wait=0 with data valid in the next cycle; the stall SHALL re-arm when cs drops.
REQ-018 Host reads of the data window SHALL return 0x00 when no bank is FULL.
REQ-019 Host register reads (a[9]=0, a[1:0]) SHALL have zero wait: 0 = {sector_ready, overrun, seq_err, 1'b0, full_count[1:0], fill_bank, rd_bank}; 1 = expected[7:0]; 2 = {7'b0, expected[8]}; 3 = 0x00.
REQ-020 Host write to reg 0 with bit0=1: SHALL release bank[rd_bank] to EMPTY and advance rd_bank; this is ignored if the bank is not FULL.
REQ-021 Host write to reg 0 with bit7=1: SHALL clear overrun and seq_err.
REQ-022 Release and a DMA strobe in the same cycle SHALL both take effect; a strobe landing on the bank being released is treated as seeing the pre-release state (FULL -> overrun).
REQ-023 Flag set and clear in the same cycle: set SHALL win.

Reset
REQ-024 On rst: all banks EMPTY, fill_bank=rd_bank=0, expected=0, overrun=seq_err=0, sram_d_out=0x00, sram_wait=0, sector_ready=0; RAM contents are undefined.

Configuration
REQ-025 Macro SDCARD_SECTOR_BUFFER_DOUBLE_EN:
- Defined: NB=2 (ping-pong); the host may read one bank while the other fills.
- Undefined: NB=1; fill_bank and rd_bank are tied to 0, full_count ≤ 1, and the status register layout is unchanged.

Verification
REQ-026 Reset, then 512 strobes with addr 0..511 and data=addr[7:0] -> sector_ready=1; a data-window read at 0x205 returns 0x05 after exactly one wait cycle; status bank0 FULL, full_count=1.
REQ-027 With DOUBLE_EN, two full sectors (data 0xA5 and 0x3C), then release -> the first read returns 0xA5, and after release returns 0x3C; a second release gives sector_ready=0.
REQ-028 Strobes addr 0,1,2,7 -> seq_err=1, bank EMPTY, sector_ready=0; write 0x80 to reg 0 -> seq_err=0.
REQ-029 All banks FULL, then a strobe at addr=0 -> overrun=1, stored data unchanged; a release in the same cycle as the strobe -> overrun still set.
REQ-030 rst asserted mid-fill at addr 300 -> all status 0 on the next cycle; a new sector from addr 0 is accepted normally.

Source files
------------

// File: rtl/sdcard_sector_buffer.sv
// SD DMA sector buffer: one or two 512-byte banks filled by the DMA stream and drained by a host SRAM-style bus.
// Define SDCARD_SECTOR_BUFFER_DOUBLE_EN for two ping-pong banks; otherwise a single bank is built.
module sdcard_sector_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dma_data,
  input  logic [8:0] dma_addr,
  input  logic       dma_strobe,
  input  logic [9:0] sram_a,
  input  logic [7:0] sram_d_in,
  output logic [7:0] sram_d_out,
  input  logic       sram_cs,
  input  logic       sram_oe,
  input  logic       sram_we,
  output logic       sram_wait,
  output logic       sector_ready
);

`ifdef SDCARD_SECTOR_BUFFER_DOUBLE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int DATA_W = 8;
  localparam int MW     = $clog2(NB * 512);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [DATA_W-1:0] mem [NB*512];
  logic [DATA_W-1:0] rd_data_q;

  logic [1:0] bank_st_q [2];
  logic [1:0] bank_st_d [2];
  logic       fill_bank_q, fill_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [8:0] expected_q, expected_d;
  logic       overrun_q, overrun_d;
  logic       seq_err_q, seq_err_d;
  logic       drop_q, drop_d;
  logic       rd_armed_q, rd_armed_d;
  logic       wr_prev_q, wr_prev_d;

  logic          mem_we;
  logic [MW-1:0] wr_idx, rd_idx;
  logic [1:0]    full_count;
  logic [1:0]    fill_st;
  logic          ovr_set, seq_set, flag_clr, wr_act, reg0_wr;
  logic          unused_d_in_bits;

  function automatic logic next_bank(input logic b);
    next_bank = (NB == 2) ? ~b : 1'b0;
  endfunction

`ifdef SDCARD_SECTOR_BUFFER_DOUBLE_EN
  assign wr_idx = {fill_bank_q, dma_addr};
  assign rd_idx = {rd_bank_q, sram_a[8:0]};
`else
  assign wr_idx = dma_addr;
  assign rd_idx = sram_a[8:0];
`endif

  assign unused_d_in_bits = ^sram_d_in[6:1];
  assign full_count   = {1'b0, bank_st_q[0] == ST_FULL} + {1'b0, bank_st_q[1] == ST_FULL};
  assign sector_ready = (full_count != 2'd0);
  assign fill_st      = bank_st_q[fill_bank_q];

  always_comb begin
    bank_st_d   = bank_st_q;
    fill_bank_d = fill_bank_q;
    rd_bank_d   = rd_bank_q;
    expected_d  = expected_q;
    drop_d      = drop_q;
    mem_we      = 1'b0;
    ovr_set     = 1'b0;
    seq_set     = 1'b0;

    // Host writes act once per cs&we assertion, not on every held cycle
    wr_act     = sram_cs & sram_we & ~wr_prev_q;
    wr_prev_d  = sram_cs & sram_we;
    reg0_wr    = wr_act & ~sram_a[9] & (sram_a[1:0] == 2'd0);
    flag_clr   = reg0_wr & sram_d_in[7];
    rd_armed_d = sram_cs & (rd_armed_q | (sram_oe & sram_a[9]));

    // After an overrun, the rest of that sector is discarded until a new addr=0
    if (dma_strobe && !(drop_q && dma_addr != 9'd0)) begin
      if (fill_st == ST_FULL) begin
        ovr_set = 1'b1;
        drop_d  = 1'b1;
      end else if (dma_addr == 9'd0) begin
        mem_we                 = 1'b1;
        bank_st_d[fill_bank_q] = ST_FILLING;
        expected_d             = 9'd1;
        drop_d                 = 1'b0;
      end else if (fill_st == ST_EMPTY) begin
        seq_set = 1'b1;
      end else if (dma_addr == expected_q) begin
        mem_we     = 1'b1;
        expected_d = expected_q + 9'd1;
        if (&dma_addr) begin
          bank_st_d[fill_bank_q] = ST_FULL;
          fill_bank_d            = next_bank(fill_bank_q);
        end
      end else begin
        seq_set                = 1'b1;
        bank_st_d[fill_bank_q] = ST_EMPTY;
      end
    end

    // Release tests the pre-strobe state, so a strobe on a FULL bank still overruns
    if (reg0_wr && sram_d_in[0] && bank_st_q[rd_bank_q] == ST_FULL) begin
      bank_st_d[rd_bank_q] = ST_EMPTY;
      rd_bank_d            = next_bank(rd_bank_q);
    end

    overrun_d = ovr_set | (overrun_q & ~flag_clr);
    seq_err_d = seq_set | (seq_err_q & ~flag_clr);
  end

  always_comb begin
    sram_wait  = 1'b0;
    sram_d_out = 8'h00;
    if (!rst && sram_cs && sram_oe) begin
      if (sram_a[9]) begin
        sram_wait = ~rd_armed_q;
        if (rd_armed_q && sector_ready) sram_d_out = rd_data_q;
      end else begin
        case (sram_a[1:0])
          2'd0:    sram_d_out = {sector_ready, overrun_q, seq_err_q, 1'b0,
                                 full_count, fill_bank_q, rd_bank_q};
          2'd1:    sram_d_out = expected_q[7:0];
          2'd2:    sram_d_out = {7'b0, expected_q[8]};
          default: sram_d_out = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= ST_EMPTY;
      bank_st_q[1] <= ST_EMPTY;
      fill_bank_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      expected_q   <= 9'd0;
      overrun_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      drop_q       <= 1'b0;
      rd_armed_q   <= 1'b0;
      wr_prev_q    <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      fill_bank_q  <= fill_bank_d;
      rd_bank_q    <= rd_bank_d;
      expected_q   <= expected_d;
      overrun_q    <= overrun_d;
      seq_err_q    <= seq_err_d;
      drop_q       <= drop_d;
      rd_armed_q   <= rd_armed_d;
      wr_prev_q    <= wr_prev_d;
    end
  end

  // Sector storage: synchronous write from DMA, registered read for the host wait cycle
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= dma_data;
    rd_data_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_sdcard_sector_buffer.sv
// Directed self-checking bench for sdcard_sector_buffer; follows SDCARD_SECTOR_BUFFER_DOUBLE_EN like the design.
module tb_sdcard_sector_buffer;

`ifdef SDCARD_SECTOR_BUFFER_DOUBLE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dma_data;
  logic [8:0] dma_addr;
  logic       dma_strobe;
  logic [9:0] sram_a;
  logic [7:0] sram_d_in;
  logic [7:0] sram_d_out;
  logic       sram_cs, sram_oe, sram_we;
  logic       sram_wait;
  logic       sector_ready;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic fb, rb;
  logic [7:0] v;

  sdcard_sector_buffer dut (
    .clk(clk), .rst(rst),
    .dma_data(dma_data), .dma_addr(dma_addr), .dma_strobe(dma_strobe),
    .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(sram_d_out),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_wait(sram_wait), .sector_ready(sector_ready)
  );

  always #5 clk = ~clk;

  function automatic logic nb(input logic b);
    nb = (NB == 2) ? ~b : 1'b0;
  endfunction

  function automatic logic [7:0] st(input logic sr, input logic ov, input logic se, input logic [1:0] fc);
    st = {sr, ov, se, 1'b0, fc, fb, rb};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [8:0] a, input logic [7:0] d);
    dma_addr = a; dma_data = d; dma_strobe = 1'b1;
    tick();
    dma_strobe = 1'b0;
  endtask

  task automatic fill(input logic [7:0] d, input bit use_addr);
    for (int i = 0; i < 512; i++) strobe(9'(i), use_addr ? 8'(i) : d);
    fb = nb(fb);
  endtask

  task automatic reg_wr(input logic [7:0] d);
    sram_a = 10'h000; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
    tick();
    sram_cs = 1'b0; sram_we = 1'b0;
    tick();
  endtask

  task automatic reg_rd(input logic [1:0] r, output logic [7:0] val);
    sram_a = {8'b0, r}; sram_cs = 1'b1; sram_oe = 1'b1;
    #1;
    val = sram_d_out;
    sram_cs = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    logic [7:0] val;
    reg_rd(r, val);
    chk(tag, val, exp);
  endtask

  task automatic win_rd(input string tag, input logic [9:0] a, input logic [7:0] exp);
    sram_a = a; sram_cs = 1'b1; sram_oe = 1'b1;
    #1;
    chk({tag, "_wait1"}, 8'(sram_wait), 8'h01);
    tick();
    chk({tag, "_wait0"}, 8'(sram_wait), 8'h00);
    chk({tag, "_data"}, sram_d_out, exp);
    sram_cs = 1'b0; sram_oe = 1'b0;
    tick();
  endtask

  task automatic release_with_strobe(input logic [8:0] a, input logic [7:0] wd);
    sram_a = 10'h000; sram_d_in = wd; sram_cs = 1'b1; sram_we = 1'b1;
    dma_addr = a; dma_data = 8'hEE; dma_strobe = 1'b1;
    tick();
    sram_cs = 1'b0; sram_we = 1'b0; dma_strobe = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; dma_data = '0; dma_addr = '0; dma_strobe = 1'b0;
    sram_a = '0; sram_d_in = '0; sram_cs = 1'b0; sram_oe = 1'b0; sram_we = 1'b0;
    fb = 1'b0; rb = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 8'(sector_ready), 8'h00);
    chk("rst_dout", sram_d_out, 8'h00);
    chk("rst_wait", 8'(sram_wait), 8'h00);
    chk_reg("rst_status", 2'd0, 8'h00);
    chk_reg("rst_expected", 2'd1, 8'h00);

    // One full sector with data = addr[7:0]
    fill(8'h00, 1'b1);
    chk("full_ready", 8'(sector_ready), 8'h01);
    chk_reg("full_status", 2'd0, st(1'b1, 1'b0, 1'b0, 2'd1));
    chk_reg("full_expected", 2'd1, 8'h00);
    chk_reg("reg3", 2'd3, 8'h00);
    win_rd("r205", 10'h205, 8'h05);
    win_rd("r3ff", 10'h3FF, 8'hFF);

    // Release, empty-window read, release of a non-FULL bank ignored
    reg_wr(8'h01); rb = nb(rb);
    chk("rel_ready", 8'(sector_ready), 8'h00);
    chk_reg("rel_status", 2'd0, st(1'b0, 1'b0, 1'b0, 2'd0));
    win_rd("empty", 10'h205, 8'h00);
    reg_wr(8'h01);
    chk_reg("rel2_status", 2'd0, st(1'b0, 1'b0, 1'b0, 2'd0));

`ifdef SDCARD_SECTOR_BUFFER_DOUBLE_EN
    fill(8'hA5, 1'b0);
    fill(8'h3C, 1'b0);
    chk_reg("pp_status", 2'd0, st(1'b1, 1'b0, 1'b0, 2'd2));
    win_rd("pp_a5", 10'h200, 8'hA5);
    reg_wr(8'h01); rb = nb(rb);
    win_rd("pp_3c", 10'h3FF, 8'h3C);
    chk_reg("pp_status1", 2'd0, st(1'b1, 1'b0, 1'b0, 2'd1));
    reg_wr(8'h01); rb = nb(rb);
    chk("pp_ready0", 8'(sector_ready), 8'h00);
`endif

    // Overrun with all banks FULL
    fill(8'h11, 1'b0);
`ifdef SDCARD_SECTOR_BUFFER_DOUBLE_EN
    fill(8'h22, 1'b0);
`endif
    chk_reg("ovr_pre", 2'd0, st(1'b1, 1'b0, 1'b0, 2'(NB)));
    strobe(9'd0, 8'hEE);
    chk_reg("ovr_set", 2'd0, st(1'b1, 1'b1, 1'b0, 2'(NB)));
    win_rd("ovr_keep", 10'h200, 8'h11);
    strobe(9'd1, 8'hEE);
    chk_reg("ovr_drop", 2'd0, st(1'b1, 1'b1, 1'b0, 2'(NB)));
    reg_wr(8'h80);
    chk_reg("ovr_clr", 2'd0, st(1'b1, 1'b0, 1'b0, 2'(NB)));
    release_with_strobe(9'd0, 8'h01); rb = nb(rb);
    chk_reg("ovr_rel", 2'd0, st(1'(NB == 2), 1'b1, 1'b0, 2'(NB - 1)));

    // Partial fill to addr 300, then reset
    for (int i = 0; i <= 300; i++) strobe(9'(i), 8'(i));
    chk_reg("mid_exp_lo", 2'd1, 8'h2D);
    chk_reg("mid_exp_hi", 2'd2, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0; fb = 1'b0; rb = 1'b0;
    chk_reg("mrst_status", 2'd0, 8'h00);
    chk_reg("mrst_exp_lo", 2'd1, 8'h00);
    chk_reg("mrst_exp_hi", 2'd2, 8'h00);
    chk("mrst_ready", 8'(sector_ready), 8'h00);
    fill(8'h00, 1'b1);
    chk("new_ready", 8'(sector_ready), 8'h01);
    win_rd("r2ab", 10'h2AB, 8'hAB);

    // Sequence errors
    reg_wr(8'h01); rb = nb(rb);
    strobe(9'd0, 8'h00); strobe(9'd1, 8'h01); strobe(9'd2, 8'h02); strobe(9'd7, 8'h07);
    chk_reg("seq_status", 2'd0, st(1'b0, 1'b0, 1'b1, 2'd0));
    chk("seq_ready", 8'(sector_ready), 8'h00);
    reg_wr(8'h80);
    chk_reg("seq_clr", 2'd0, st(1'b0, 1'b0, 1'b0, 2'd0));
    strobe(9'd5, 8'h05);
    chk_reg("seq_empty", 2'd0, st(1'b0, 1'b0, 1'b1, 2'd0));
    reg_wr(8'h80);
    release_with_strobe(9'd9, 8'h80);
    chk_reg("set_wins", 2'd0, st(1'b0, 1'b0, 1'b1, 2'd0));
    reg_wr(8'h80);
    strobe(9'd0, 8'h00); strobe(9'd0, 8'h00); strobe(9'd1, 8'h01);
    chk_reg("restart_exp", 2'd1, 8'h02);
    chk_reg("restart_status", 2'd0, st(1'b0, 1'b0, 1'b0, 2'd0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
